grid_frame_reader: RTL and testbench
====================================

// Module: grid_frame_reader
// PURPOSE
//  Downstream consumer of the cell array. On a generation-done strobe it
//  snapshots the flat Status bus of all WIDTH*HEIGHT cells. It then streams
//  the frame out one cell per handshake, row-major, to the display/UART side.
//  Frees the cell array to compute the next generation while the frame drains.
// PARAMETERS
//  WIDTH   8   cells per row (>=2)
//  HEIGHT  8   rows per frame (>=2)
//  GEN_W   16  width of generation counter
// PORTS
//  clk        in   1                     system clock; all logic on posedge
//  rst        in   1                     synchronous reset, active-high
//  cells_in   in   WIDTH*HEIGHT          cell Status bus; bit r*WIDTH+c = cell (r,c)
//  snap       in   1                     1-cycle strobe: generation settled, capture frame
//  out_valid  out  1                     out_bit/out_col/out_row/out_eol/out_eof valid
//  out_ready  in   1                     sink accepts current cell
//  out_bit    out  1                     alive(1)/dead(0) of current cell
//  out_col    out  $clog2(WIDTH)         column of current cell
//  out_row    out  $clog2(HEIGHT)        row of current cell
//  out_eol    out  1                     current cell is last in its row (col==WIDTH-1)
//  out_eof    out  1                     current cell is last in frame
//  busy       out  1                     frame being streamed
//  overrun    out  1                     sticky: snap arrived while busy and was dropped
//  gen_count  out  GEN_W                 number of accepted snapshots, modulo 2^GEN_W
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE.
//   All outputs 0: out_valid, busy, overrun, gen_count, col/row, bit, eol, eof.
//   Frame register cleared. Reset mid-stream abandons the frame immediately.
//  States: IDLE, STREAM.
//   IDLE & snap -> latch cells_in into frame reg; col=row=0; gen_count+1;
//    STREAM. out_valid=1 from the cycle after snap (1-cycle latency).
//   STREAM: outputs are driven from frame reg at (row,col), never from live cells_in.
//    Outputs hold stable while out_valid & !out_ready.
//    Handshake = out_valid & out_ready. On handshake: col+1.
//    At col==WIDTH-1, col wraps to 0 and row+1.
//   Final handshake (row==HEIGHT-1, col==WIDTH-1, out_eof=1):
//    without snap -> IDLE, out_valid=0 next cycle.
//    with snap same cycle -> recapture, gen_count+1, stay STREAM.
//     Next cycle presents (0,0) of the new frame; no bubble, overrun not set.
//  snap in STREAM other than on final handshake: dropped.
//   overrun<=1 (sticky until rst); frame reg and gen_count unchanged.
//  busy = (state==STREAM). out_eol/out_eof are combinational on col/row.
//   Both assert on the last cell of the frame.
//  gen_count wraps 2^GEN_W-1 -> 0 silently.
//  rst has priority over snap and handshake in the same cycle.
// CONFIGURATION
//  GRID_POP_COUNT_EN defined:
//   Adds output pop_count [$clog2(WIDTH*HEIGHT+1)-1:0].
//   pop_count = number of 1s in the frame captured on each accepted snap.
//   It is registered, valid the cycle after capture, and held until the next
//   capture. It is 0 at reset and is not updated on a dropped snap.
//  Undefined: port and popcount logic absent; all other behaviour identical.
// TESTING
//  1 W=4,H=3. rst, then snap with cells_in=12'hA5C, out_ready=1.
//    -> 12 handshakes in consecutive cycles.
//    -> bits in order 0,0,1,1,1,0,1,0,0,1,0,1 (bit0 first).
//    -> out_eol at cols 3; out_eof only at (2,3); gen_count=1; busy low after.
//  2 Same frame, out_ready toggled 1,0,0,1 repeating.
//    -> identical sequence; outputs stable during stalls.
//    -> cells_in changed to 0 after snap; streamed frame unaffected.
//  3 snap at 5th handshake.
//    -> dropped; overrun=1; stream unchanged; gen_count=1.
//    -> overrun stays 1 after frame ends, until rst.
//  4 snap on final handshake with cells_in=12'hFFF.
//    -> next cycle out_valid=1 at (0,0) with bit 1; gen_count=2; overrun=0.
//  5 rst asserted mid-stream at (1,2).
//    -> next cycle out_valid=0, busy=0, gen_count=0, row=col=0.
//    -> a subsequent snap streams normally.
//  6 GRID_POP_COUNT_EN: snap with 12'hA5C -> pop_count=6.
//    Then GEN_W=2 with 5 snaps -> gen_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/grid_frame_reader.sv
// ----------------------------------------------------------------------------
// grid_frame_reader
//
// Captures a snapshot of the flat cell Status bus when a generation-done
// strobe arrives. It then streams that frame out one cell per valid/ready
// handshake, in row-major order. Because the snapshot is held locally, the
// cell array is free to compute the next generation while the frame drains.
//
// Parameters
//   WIDTH   cells per row (>=2)
//   HEIGHT  rows per frame (>=2)
//   GEN_W   width of the generation counter
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active-high
//   cells_in   live cell Status bus, bit r*WIDTH+c = cell (r,c)
//   snap       1-cycle strobe: generation settled, capture the frame
//   out_valid  current cell outputs are valid
//   out_ready  sink accepts the current cell
//   out_bit    alive(1)/dead(0) of the current cell
//   out_col    column of the current cell
//   out_row    row of the current cell
//   out_eol    current cell is the last one in its row
//   out_eof    current cell is the last one in the frame
//   busy       a frame is being streamed
//   overrun    sticky: a snap arrived while busy and was dropped
//   gen_count  number of accepted snapshots, modulo 2^GEN_W
//   pop_count  (only with GRID_POP_COUNT_EN) number of live cells in the
//              most recently captured frame
//
// Optional feature macro: GRID_POP_COUNT_EN adds the pop_count output.
// ----------------------------------------------------------------------------
module grid_frame_reader #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WIDTH*HEIGHT-1:0]            cells_in,
    input  logic                               snap,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_bit,
    output logic [$clog2(WIDTH)-1:0]           out_col,
    output logic [$clog2(HEIGHT)-1:0]          out_row,
    output logic                               out_eol,
    output logic                               out_eof,
    output logic                               busy,
    output logic                               overrun,
    output logic [GEN_W-1:0]                   gen_count
`ifdef GRID_POP_COUNT_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]  pop_count
`endif
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [N-1:0]        frame_reg, frame_next;
    logic [CW-1:0]       col_reg, col_next;
    logic [RW-1:0]       row_reg, row_next;
    logic [GEN_W-1:0]    gen_reg, gen_next;
    logic                overrun_reg, overrun_next;

    logic                handshake;
    logic                last_cell;
    logic                capture;

    // Split the snapshot into rows so the output mux is a plain 2-D select.
    logic [WIDTH-1:0]    frame_rows [HEIGHT];

    generate
        for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_rows
            assign frame_rows[gi] = frame_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output decode. eol/eof are purely positional; in IDLE the position
    // is parked at (0,0) so both read low there.
    // ------------------------------------------------------------------
    assign out_valid = (state_reg == STREAM);
    assign busy      = (state_reg == STREAM);
    assign out_bit   = frame_rows[row_reg][col_reg];
    assign out_col   = col_reg;
    assign out_row   = row_reg;
    assign out_eol   = (col_reg == CW'(WIDTH - 1));
    assign out_eof   = out_eol && (row_reg == RW'(HEIGHT - 1));
    assign overrun   = overrun_reg;
    assign gen_count = gen_reg;

    assign handshake = (state_reg == STREAM) && out_ready;
    assign last_cell = out_eof;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        frame_next   = frame_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        gen_next     = gen_reg;
        overrun_next = overrun_reg;
        capture      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (snap) begin
                    capture = 1'b1;
                end
            end

            STREAM: begin
                if (handshake) begin
                    if (last_cell) begin
                        // A snap landing exactly on the final handshake
                        // starts the next frame with no bubble.
                        if (snap) begin
                            capture = 1'b1;
                        end else begin
                            state_next = IDLE;
                            col_next   = '0;
                            row_next   = '0;
                        end
                    end else if (col_reg == CW'(WIDTH - 1)) begin
                        col_next = '0;
                        row_next = row_reg + RW'(1);
                    end else begin
                        col_next = col_reg + CW'(1);
                    end
                end

                // Any other snap during streaming is lost; flag it.
                if (snap && !(handshake && last_cell)) begin
                    overrun_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (capture) begin
            state_next = STREAM;
            frame_next = cells_in;
            col_next   = '0;
            row_next   = '0;
            gen_next   = gen_reg + GEN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            frame_reg   <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            gen_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            frame_reg   <= frame_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            gen_reg     <= gen_next;
            overrun_reg <= overrun_next;
        end
    end

`ifdef GRID_POP_COUNT_EN
    // ------------------------------------------------------------------
    // Population count of the incoming bus, registered only when a frame
    // is actually captured so it always describes the frame in flight.
    // ------------------------------------------------------------------
    localparam int PW = $clog2(N + 1);

    logic [PW-1:0] pop_sum;
    logic [PW-1:0] pop_reg;

    always_comb begin
        pop_sum = '0;
        for (int i = 0; i < N; i++) begin
            pop_sum = pop_sum + PW'(cells_in[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_reg <= '0;
        end else if (capture) begin
            pop_reg <= pop_sum;
        end
    end

    assign pop_count = pop_reg;
`endif

endmodule

// File: tb/tb_grid_frame_reader.sv
// ----------------------------------------------------------------------------
// Testbench for grid_frame_reader (WIDTH=4, HEIGHT=3).
// A second instance with GEN_W=2 shares all inputs so that generation
// counter wrap-around is observed on every cycle.
// ----------------------------------------------------------------------------
module tb_grid_frame_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int PW = $clog2(N + 1);

    logic           clk;
    logic           rst;
    logic [N-1:0]   cells_in;
    logic           snap;
    logic           out_ready;

    logic           out_valid, out_bit, out_eol, out_eof, busy, overrun;
    logic [1:0]     out_col;
    logic [1:0]     out_row;
    logic [15:0]    gen_count;

    logic           out_valid2, out_bit2, out_eol2, out_eof2, busy2, overrun2;
    logic [1:0]     out_col2;
    logic [1:0]     out_row2;
    logic [1:0]     gen_count2;

`ifdef GRID_POP_COUNT_EN
    logic [PW-1:0]  pop_count;
    logic [PW-1:0]  pop_count2;
`endif

    grid_frame_reader #(.WIDTH(W), .HEIGHT(H), .GEN_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cells_in  (cells_in),
        .snap      (snap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_col   (out_col),
        .out_row   (out_row),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .overrun   (overrun),
        .gen_count (gen_count)
`ifdef GRID_POP_COUNT_EN
        ,
        .pop_count (pop_count)
`endif
    );

    grid_frame_reader #(.WIDTH(W), .HEIGHT(H), .GEN_W(2)) u_dut_gen2 (
        .clk       (clk),
        .rst       (rst),
        .cells_in  (cells_in),
        .snap      (snap),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_bit   (out_bit2),
        .out_col   (out_col2),
        .out_row   (out_row2),
        .out_eol   (out_eol2),
        .out_eof   (out_eof2),
        .busy      (busy2),
        .overrun   (overrun2),
        .gen_count (gen_count2)
`ifdef GRID_POP_COUNT_EN
        ,
        .pop_count (pop_count2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: a frame is a list of N cells and a linear read
    // position; row/column fall out of division by W.
    // ------------------------------------------------------------------
    bit m_busy;
    bit m_frame [N];
    int m_pos;
    int m_gen;
    bit m_ovr;
    int m_pop;

    task automatic model_step(input bit r, input bit s, input bit rdy,
                              input logic [N-1:0] c);
        bit hs;
        bit fin;
        bit accept;
        if (r) begin
            m_busy = 0; m_pos = 0; m_gen = 0; m_ovr = 0; m_pop = 0;
            for (int i = 0; i < N; i++) m_frame[i] = 0;
            return;
        end
        hs     = m_busy && rdy;
        fin    = hs && (m_pos == N - 1);
        accept = s && (!m_busy || fin);
        if (s && !accept) m_ovr = 1;
        if (accept) begin
            for (int i = 0; i < N; i++) m_frame[i] = c[i];
            m_pos  = 0;
            m_gen  = m_gen + 1;
            m_busy = 1;
            m_pop  = $countones(c);
        end else if (hs) begin
            if (fin) begin
                m_busy = 0;
                m_pos  = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_busy));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("out_bit",   32'(out_bit),   32'(m_frame[m_pos]));
        chk("out_col",   32'(out_col),   32'(m_pos % W));
        chk("out_row",   32'(out_row),   32'(m_pos / W));
        chk("out_eol",   32'(out_eol),   32'((m_pos % W) == W - 1));
        chk("out_eof",   32'(out_eof),   32'(m_pos == N - 1));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        chk("gen_count", 32'(gen_count), 32'(m_gen % 65536));
        chk("gen_count_w2", 32'(gen_count2), 32'(m_gen % 4));
`ifdef GRID_POP_COUNT_EN
        chk("pop_count", 32'(pop_count), 32'(m_pop));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic cycle(input bit r, input bit s, input bit rdy,
                         input logic [N-1:0] c);
        rst = r; snap = s; out_ready = rdy; cells_in = c;
        model_step(r, s, rdy, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        bit       ready;
        bit       exp_bit;
        int       exp_col;
        int       exp_row;
        bit       exp_eol;
        bit       exp_eof;
    } vec_t;

    vec_t tbl [N];
    logic [N-1:0] pat;
    int   bits_seen [$];
    int   gen_w2_exp [5];

    initial begin
        rst = 1'b1; snap = 1'b0; out_ready = 1'b0; cells_in = '0;

        // Expected stream of frame 12'hA5C, bit 0 first.
        pat = 12'hA5C;
        for (int i = 0; i < N; i++) begin
            tbl[i].ready   = 1'b1;
            tbl[i].exp_bit = pat[i];
            tbl[i].exp_col = i % W;
            tbl[i].exp_row = i / W;
            tbl[i].exp_eol = (i % W) == W - 1;
            tbl[i].exp_eof = (i == N - 1);
        end
        gen_w2_exp = '{1, 2, 3, 0, 1};

        // ---- 1: basic frame, ready always high ----
        cycle(1, 0, 1, '0);
        cycle(1, 0, 1, '0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_gen",   32'(gen_count), 32'd0);
        cycle(0, 1, 1, 12'hA5C);
`ifdef GRID_POP_COUNT_EN
        chk("pop_a5c", 32'(pop_count), 32'd6);
`endif
        for (int i = 0; i < N; i++) begin
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_bit",   32'(out_bit),   32'(tbl[i].exp_bit));
            chk("t1_col",   32'(out_col),   32'(tbl[i].exp_col));
            chk("t1_row",   32'(out_row),   32'(tbl[i].exp_row));
            chk("t1_eol",   32'(out_eol),   32'(tbl[i].exp_eol));
            chk("t1_eof",   32'(out_eof),   32'(tbl[i].exp_eof));
            cycle(0, 0, tbl[i].ready, 12'hA5C);
        end
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_gen",        32'(gen_count), 32'd1);

        // ---- 2: stalls 1,0,0,1 with live bus cleared after the snap ----
        cycle(1, 0, 0, '0);
        cycle(0, 1, 0, 12'hA5C);
        bits_seen.delete();
        for (int k = 0; k < 100 && busy; k++) begin
            bit rdy;
            rdy = ((k % 4) == 0) || ((k % 4) == 3);
            if (out_valid && rdy) bits_seen.push_back(int'(out_bit));
            cycle(0, 0, rdy, '0);
        end
        chk("t2_drained", 32'(busy), 32'd0);
        chk("t2_count", 32'(bits_seen.size()), 32'(N));
        for (int i = 0; i < N && i < bits_seen.size(); i++)
            chk("t2_bit", 32'(bits_seen[i]), 32'(tbl[i].exp_bit));

        // ---- 3: snap on the 5th handshake is dropped ----
        cycle(1, 0, 1, '0);
        cycle(0, 1, 1, 12'hA5C);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 12'hA5C);
        cycle(0, 1, 1, 12'hFFF);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_gen",     32'(gen_count), 32'd1);
        chk("t3_bit5",    32'(out_bit), 32'(tbl[5].exp_bit));
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, '0);
        chk("t3_idle",         32'(busy), 32'd0);
        chk("t3_overrun_hold", 32'(overrun), 32'd1);

        // ---- 4: snap on the final handshake chains frames ----
        cycle(1, 0, 1, '0);
        cycle(0, 1, 1, 12'hA5C);
        for (int i = 0; i < N - 1; i++) cycle(0, 0, 1, 12'hA5C);
        chk("t4_at_eof", 32'(out_eof), 32'd1);
        cycle(0, 1, 1, 12'hFFF);
        chk("t4_valid",   32'(out_valid), 32'd1);
        chk("t4_col",     32'(out_col), 32'd0);
        chk("t4_row",     32'(out_row), 32'd0);
        chk("t4_bit",     32'(out_bit), 32'd1);
        chk("t4_gen",     32'(gen_count), 32'd2);
        chk("t4_overrun", 32'(overrun), 32'd0);
`ifdef GRID_POP_COUNT_EN
        chk("t4_pop", 32'(pop_count), 32'd12);
`endif
        for (int i = 0; i < N; i++) cycle(0, 0, 1, '0);

        // ---- 5: reset mid-stream at (1,2) ----
        cycle(1, 0, 1, '0);
        cycle(0, 1, 1, 12'hA5C);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, '0);
        chk("t5_row", 32'(out_row), 32'd1);
        chk("t5_col", 32'(out_col), 32'd2);
        cycle(1, 1, 1, 12'hFFF);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy",  32'(busy), 32'd0);
        chk("t5_gen",   32'(gen_count), 32'd0);
        chk("t5_pos",   32'({out_row, out_col}), 32'd0);
        cycle(0, 1, 1, 12'h3C3);
        for (int i = 0; i < N; i++) cycle(0, 0, 1, '0);
        chk("t5_done", 32'(busy), 32'd0);

        // ---- 6: generation counter wrap on the GEN_W=2 instance ----
        cycle(1, 0, 1, '0);
        for (int s = 0; s < 5; s++) begin
            cycle(0, 1, 1, 12'h001);
            chk("t6_gen_w2", 32'(gen_count2), 32'(gen_w2_exp[s]));
            for (int i = 0; i < N; i++) cycle(0, 0, 1, '0);
        end

        // ---- random traffic against the model ----
        cycle(1, 0, 0, '0);
        for (int k = 0; k < 4000; k++) begin
            bit r, s, rdy;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(r, s, rdy, N'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
